vec_mem_scheduler: RTL and testbench

Time-multiplexes the single image-memory port between a 3-lane vector load/store requester and the VGA display read channel. It replaces free-running slot counters with a request/ready handshake, latches the lane addresses, and sequences one memory access per cycle. It returns per-lane read data as a vector and gives the display channel bounded priority. It sits between the filter datapath and the image RAM, beside the image drawer.

---
 rtl/vec_mem_sched_pkg.sv | 17 +
 rtl/vec_mem_starve_ctr.sv | 31 +++
 rtl/vec_mem_scheduler.sv | 152 +++++++++++++++
 tb/tb_vec_mem_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_sched_pkg.sv
// Shared types and defaults for the vector/display memory-port scheduler.
package vec_mem_sched_pkg;

  localparam int DEF_N_LANES = 3;
  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_DATA_W  = 18;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  // Owner of the access presented in the previous cycle; lane index is carried separately.
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_LANE} tag_e;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_mem_starve_ctr.sv
// Counts consecutive display grants during a vector operation and forces one vector slot at the limit.
module vec_mem_starve_ctr #(
  parameter int MAX_STALL = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  input  logic grant_i,
  output logic force_o
);

  localparam int CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_STALL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (issue_i && grant_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_o = (MAX_STALL != 0) && issue_i && (cnt_q == LIMIT);

endmodule

// File: rtl/vec_mem_scheduler.sv
// Shares one image-memory port between a multi-lane vector load/store requester and the display reader.
module vec_mem_scheduler
  import vec_mem_sched_pkg::*;
#(
  parameter int N_LANES   = DEF_N_LANES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_STALL = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        vec_req,
  input  logic                        vec_we,
  input  logic [N_LANES*ADDR_W-1:0]   vec_addr,
  input  logic [N_LANES*DATA_W-1:0]   vec_wdata,
  output logic                        vec_ready,
  output logic                        vec_done,
  output logic [N_LANES*DATA_W-1:0]   ReadDataVec,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic                        disp_grant,
  output logic                        disp_valid,
  output logic [DATA_W-1:0]           disp_data,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int LANE_W = lane_w(N_LANES);
  localparam logic [LANE_W-1:0] LAST = LANE_W'(N_LANES - 1);

  state_e            state_q, state_d;
  tag_e              tag_q, tag_d;
  logic [LANE_W-1:0] lane_q, lane_d, tag_idx_q, tag_idx_d;
  logic              done_q, done_d, we_q, disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [ADDR_W-1:0] addr_q  [N_LANES];
  logic [DATA_W-1:0] wdata_q [N_LANES];
  logic [DATA_W-1:0] rdv_q   [N_LANES];
  logic              force_slot, in_issue, slot, accept;

  assign in_issue   = (state_q == ISSUE);
  assign accept     = (state_q == IDLE) && vec_req;
  assign disp_grant = disp_req && !force_slot;
  assign slot       = in_issue && !disp_grant;

  vec_mem_starve_ctr #(.MAX_STALL(MAX_STALL)) u_starve (
    .clk_i   (CLK),
    .rst_i   (RST),
    .issue_i (in_issue),
    .grant_i (disp_grant),
    .force_o (force_slot)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    done_d    = 1'b0;
    tag_d     = TAG_NONE;
    tag_idx_d = '0;
    case (state_q)
      IDLE: begin
        if (vec_req) begin
          state_d = ISSUE;
          lane_d  = '0;
        end
      end
      ISSUE: begin
        if (slot) begin
          if (lane_q == LAST) begin
            lane_d  = '0;
            state_d = we_q ? IDLE : DRAIN;
            done_d  = we_q;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Stores never return data, so their slots leave the tag empty.
    if (disp_grant) begin
      tag_d = TAG_DISP;
    end else if (slot && !we_q) begin
      tag_d     = TAG_LANE;
      tag_idx_d = lane_q;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (disp_grant) begin
      mem_addr = disp_addr;
    end else if (slot) begin
      mem_addr = addr_q[lane_q];
      if (we_q) begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q[lane_q];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      tag_q        <= TAG_NONE;
      tag_idx_q    <= '0;
      done_q       <= 1'b0;
      we_q         <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      for (int i = 0; i < N_LANES; i++) rdv_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      tag_q        <= tag_d;
      tag_idx_q    <= tag_idx_d;
      done_q       <= done_d;
      disp_valid_q <= (tag_q == TAG_DISP);
      if (accept)              we_q                <= vec_we;
      if (tag_q == TAG_DISP)   disp_data_q         <= mem_rdata;
      if (tag_q == TAG_LANE)   rdv_q[tag_idx_q]    <= mem_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int i = 0; i < N_LANES; i++) begin
        addr_q[i]  <= vec_addr[i*ADDR_W +: ADDR_W];
        wdata_q[i] <= vec_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_rdv
    assign ReadDataVec[g*DATA_W +: DATA_W] = rdv_q[g];
  end

  assign vec_ready  = (state_q == IDLE);
  assign vec_done   = done_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_vec_mem_scheduler.sv
// Directed bench: two schedulers (MAX_STALL=8 and MAX_STALL=0) sharing stimulus, each with a RAM model.
module tb_vec_mem_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        vec_req, vec_we, disp_req;
  logic [56:0] vec_addr;
  logic [53:0] vec_wdata;
  logic [18:0] disp_addr;

  logic        vec_ready, vec_done, disp_grant, disp_valid, mem_we;
  logic [53:0] ReadDataVec;
  logic [17:0] disp_data, mem_wdata, mem_rdata;
  logic [18:0] mem_addr;

  logic        vec_ready0, vec_done0, disp_grant0, disp_valid0, mem_we0;
  logic [53:0] ReadDataVec0;
  logic [17:0] disp_data0, mem_wdata0, mem_rdata0;
  logic [18:0] mem_addr0;

  logic        tb_we;
  logic [9:0]  tb_waddr;
  logic [17:0] tb_wdata;
  logic [17:0] ram [0:1023];

  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (tb_we)       ram[tb_waddr] <= tb_wdata;
    else if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
    mem_rdata  <= ram[mem_addr[9:0]];
    mem_rdata0 <= ram[mem_addr0[9:0]];
  end

  vec_mem_scheduler #(.MAX_STALL(8)) u_dut (
    .CLK(CLK), .RST(RST), .vec_req(vec_req), .vec_we(vec_we), .vec_addr(vec_addr),
    .vec_wdata(vec_wdata), .vec_ready(vec_ready), .vec_done(vec_done),
    .ReadDataVec(ReadDataVec), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_grant(disp_grant), .disp_valid(disp_valid), .disp_data(disp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  vec_mem_scheduler #(.MAX_STALL(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .vec_req(vec_req), .vec_we(vec_we), .vec_addr(vec_addr),
    .vec_wdata(vec_wdata), .vec_ready(vec_ready0), .vec_done(vec_done0),
    .ReadDataVec(ReadDataVec0), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_grant(disp_grant0), .disp_valid(disp_valid0), .disp_data(disp_data0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [17:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    cyc();
    tb_we = 1'b0;
  endtask

  task automatic test_reset();
    // Start a load with display traffic, then hold reset for three edges.
    vec_addr = {19'd30, 19'd20, 19'd10}; vec_we = 1'b0; vec_req = 1'b1;
    disp_req = 1'b1; disp_addr = 19'd5;
    cyc(); vec_req = 1'b0;
    cyc();
    RST = 1'b1;
    repeat (3) cyc();
    RST = 1'b0; disp_req = 1'b0; #1;
    n_chk++; if (vec_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", vec_ready); else n_pass++;
    n_chk++; if (vec_done !== 1'b0) $display("FAIL reset_done got %b want 0", vec_done); else n_pass++;
    n_chk++; if (disp_valid !== 1'b0) $display("FAIL reset_dvalid got %b want 0", disp_valid); else n_pass++;
    n_chk++; if (disp_data !== 18'h0) $display("FAIL reset_ddata got %h want 0", disp_data); else n_pass++;
    n_chk++; if (ReadDataVec !== 54'h0) $display("FAIL reset_rdv got %h want 0", ReadDataVec); else n_pass++;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else n_pass++;
    n_chk++; if (mem_addr !== 19'h0) $display("FAIL reset_addr got %h want 0", mem_addr); else n_pass++;
  endtask

  task automatic test_load();
    vec_addr = {19'd30, 19'd20, 19'd10}; vec_we = 1'b0; vec_req = 1'b1; #1;
    n_chk++; if (vec_ready !== 1'b1) $display("FAIL load_ready_c0 got %b want 1", vec_ready); else n_pass++;
    for (int c = 1; c <= 6; c++) begin
      cyc(); vec_req = 1'b0; #1;
      n_chk++; if (vec_done !== (c == 5)) $display("FAIL load_done c%0d got %b want %b", c, vec_done, (c == 5)); else n_pass++;
      n_chk++; if (vec_ready !== (c >= 5)) $display("FAIL load_ready c%0d got %b want %b", c, vec_ready, (c >= 5)); else n_pass++;
      if (c <= 3) begin
        n_chk++; if (mem_addr !== 19'(10 * c) || mem_we !== 1'b0)
          $display("FAIL load_addr c%0d got %0d/%b want %0d/0", c, mem_addr, mem_we, 10 * c); else n_pass++;
      end
      if (c == 5) begin
        n_chk++; if (ReadDataVec !== {18'h333, 18'h222, 18'h111})
          $display("FAIL load_data got %h want %h", ReadDataVec, {18'h333, 18'h222, 18'h111}); else n_pass++;
      end
    end
  endtask

  task automatic test_store();
    vec_addr = {19'd102, 19'd101, 19'd100}; vec_wdata = {18'h3, 18'h2, 18'h1};
    vec_we = 1'b1; vec_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc(); vec_req = 1'b0; #1;
      if (c <= 3) begin
        n_chk++; if (mem_we !== 1'b1 || mem_addr !== 19'(99 + c) || mem_wdata !== 18'(c))
          $display("FAIL store_wr c%0d got %b/%0d/%h want 1/%0d/%h", c, mem_we, mem_addr, mem_wdata, 99 + c, c); else n_pass++;
        n_chk++; if (mem_we0 !== 1'b1 || mem_wdata0 !== 18'(c))
          $display("FAIL store_wr0 c%0d got %b/%h want 1/%h", c, mem_we0, mem_wdata0, c); else n_pass++;
      end else begin
        n_chk++; if (mem_we !== 1'b0) $display("FAIL store_we_off c%0d got %b want 0", c, mem_we); else n_pass++;
      end
      n_chk++; if (vec_done !== (c == 4)) $display("FAIL store_done c%0d got %b want %b", c, vec_done, (c == 4)); else n_pass++;
    end
    vec_addr = {19'd102, 19'd101, 19'd100}; vec_we = 1'b0; vec_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc(); vec_req = 1'b0; #1;
    end
    n_chk++; if (vec_done !== 1'b1 || ReadDataVec !== {18'h3, 18'h2, 18'h1})
      $display("FAIL store_readback got %b/%h want 1/%h", vec_done, ReadDataVec, {18'h3, 18'h2, 18'h1}); else n_pass++;
  endtask

  task automatic test_steal();
    vec_addr = {19'd30, 19'd20, 19'd10}; vec_we = 1'b0; vec_req = 1'b1; disp_addr = 19'd5;
    for (int c = 1; c <= 7; c++) begin
      cyc(); vec_req = 1'b0; disp_req = (c == 2); #1;
      if (c == 2) begin
        n_chk++; if (disp_grant !== 1'b1 || mem_addr !== 19'd5)
          $display("FAIL steal_grant got %b/%0d want 1/5", disp_grant, mem_addr); else n_pass++;
      end
      if (c == 3 || c == 4) begin
        n_chk++; if (mem_addr !== 19'(10 * (c - 1)))
          $display("FAIL steal_addr c%0d got %0d want %0d", c, mem_addr, 10 * (c - 1)); else n_pass++;
      end
      n_chk++; if (disp_valid !== (c == 4)) $display("FAIL steal_dvalid c%0d got %b want %b", c, disp_valid, (c == 4)); else n_pass++;
      if (c == 4) begin
        n_chk++; if (disp_data !== 18'h2A) $display("FAIL steal_ddata got %h want 2a", disp_data); else n_pass++;
      end
      n_chk++; if (vec_done !== (c == 6)) $display("FAIL steal_done c%0d got %b want %b", c, vec_done, (c == 6)); else n_pass++;
    end
    n_chk++; if (ReadDataVec !== {18'h333, 18'h222, 18'h111})
      $display("FAIL steal_data got %h want %h", ReadDataVec, {18'h333, 18'h222, 18'h111}); else n_pass++;
  endtask

  task automatic test_starve();
    logic forced;
    vec_addr = {19'd30, 19'd20, 19'd10}; vec_we = 1'b0; vec_req = 1'b1;
    disp_req = 1'b1; disp_addr = 19'd5;
    for (int c = 1; c <= 46; c++) begin
      cyc(); vec_req = 1'b0; disp_req = (c <= 40); #1;
      forced = (c == 9 || c == 18 || c == 27);
      if (c <= 40) begin
        n_chk++; if (disp_grant !== !forced) $display("FAIL starve_grant c%0d got %b want %b", c, disp_grant, !forced); else n_pass++;
        n_chk++; if (disp_grant0 !== 1'b1) $display("FAIL nopre_grant c%0d got %b want 1", c, disp_grant0); else n_pass++;
        n_chk++; if (vec_done0 !== 1'b0) $display("FAIL nopre_done c%0d got %b want 0", c, vec_done0); else n_pass++;
      end
      if (forced) begin
        n_chk++; if (mem_addr !== 19'(10 * (c / 9)))
          $display("FAIL starve_addr c%0d got %0d want %0d", c, mem_addr, 10 * (c / 9)); else n_pass++;
      end
      n_chk++; if (vec_done !== (c == 29)) $display("FAIL starve_done c%0d got %b want %b", c, vec_done, (c == 29)); else n_pass++;
      if (c == 41) begin
        n_chk++; if (mem_addr0 !== 19'd10 || disp_valid0 !== 1'b1 || disp_data0 !== 18'h2A)
          $display("FAIL nopre_resume got %0d/%b/%h want 10/1/2a", mem_addr0, disp_valid0, disp_data0); else n_pass++;
      end
      if (c > 40) begin
        n_chk++; if (vec_done0 !== (c == 45)) $display("FAIL nopre_late_done c%0d got %b want %b", c, vec_done0, (c == 45)); else n_pass++;
      end
      if (c == 45) begin
        n_chk++; if (vec_ready0 !== 1'b1 || ReadDataVec0 !== {18'h333, 18'h222, 18'h111})
          $display("FAIL nopre_data got %b/%h want 1/%h", vec_ready0, ReadDataVec0, {18'h333, 18'h222, 18'h111}); else n_pass++;
      end
    end
    n_chk++; if (ReadDataVec !== {18'h333, 18'h222, 18'h111})
      $display("FAIL starve_data got %h want %h", ReadDataVec, {18'h333, 18'h222, 18'h111}); else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    vec_addr = {19'd102, 19'd101, 19'd100}; vec_wdata = {18'h3C, 18'h2B, 18'h1A};
    vec_we = 1'b1; vec_req = 1'b1;
    cyc(); vec_req = 1'b0;
    cyc(); RST = 1'b1;
    cyc(); RST = 1'b0; #1;
    n_chk++; if (vec_ready !== 1'b1) $display("FAIL rst_store_ready got %b want 1", vec_ready); else n_pass++;
    for (int c = 3; c <= 8; c++) begin
      n_chk++; if (mem_we !== 1'b0 || vec_done !== 1'b0)
        $display("FAIL rst_store_quiet c%0d got we=%b done=%b want 0/0", c, mem_we, vec_done); else n_pass++;
      cyc();
    end
    n_chk++; if (ram[102] !== 18'h3) $display("FAIL rst_store_ram102 got %h want 3", ram[102]); else n_pass++;
    n_chk++; if (ram[101] !== 18'h2B) $display("FAIL rst_store_ram101 got %h want 2b", ram[101]); else n_pass++;
    n_chk++; if (ram[100] !== 18'h1A) $display("FAIL rst_store_ram100 got %h want 1a", ram[100]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    vec_addr = {19'd30, 19'd20, 19'd10}; vec_we = 1'b0; vec_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 5) vec_addr = {19'd102, 19'd101, 19'd100};
      vec_req = (c == 5); #1;
      n_chk++; if (vec_done !== (c == 5 || c == 10))
        $display("FAIL b2b_done c%0d got %b want %b", c, vec_done, (c == 5 || c == 10)); else n_pass++;
      if (c == 6) begin
        n_chk++; if (mem_addr !== 19'd100) $display("FAIL b2b_addr got %0d want 100", mem_addr); else n_pass++;
      end
      if (c == 10) begin
        n_chk++; if (ReadDataVec !== {18'h3, 18'h2B, 18'h1A})
          $display("FAIL b2b_data got %h want %h", ReadDataVec, {18'h3, 18'h2B, 18'h1A}); else n_pass++;
      end
    end
  endtask

  initial begin
    RST = 1'b1; vec_req = 1'b0; vec_we = 1'b0; disp_req = 1'b0;
    vec_addr = '0; vec_wdata = '0; disp_addr = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (3) cyc();
    RST = 1'b0;
    poke(10'd10, 18'h111);
    poke(10'd20, 18'h222);
    poke(10'd30, 18'h333);
    poke(10'd5, 18'h2A);
    test_load();
    test_store();
    test_steal();
    test_reset();
    test_starve();
    test_reset_mid_store();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
